// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared mux codes, FSM state encoding and default width for the UART TX path
package uart_tx_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
endpackage

// File: rtl/uart_tx_ctrl_fsm_if.sv
// uart_tx_ctrl_fsm_if: upstream handshake plus serializer control bundle
interface uart_tx_ctrl_fsm_if
  import uart_tx_pkg::*;
#(parameter int DATA_WIDTH = DATA_WIDTH_DEF);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic [DATA_WIDTH-1:0] S_DATA;
  logic                  Data_Valid;
  logic                  data_ready;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  ser_done;
  logic                  ser_en;
  logic [1:0]            mux_sel;
  logic                  par_bit;
  logic                  busy;
  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done,
    input  data_ready, ser_en, mux_sel, par_bit, S_DATA, busy
  );
  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done,
    output data_ready, ser_en, mux_sel, par_bit, S_DATA, busy
  );
endinterface

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc: XOR-reduce parity with odd/even select, shared with the RX checker
module uart_tx_parity_calc
  import uart_tx_pkg::*;
#(parameter int DATA_WIDTH = DATA_WIDTH_DEF) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  odd_i,
  output logic                  par_o
);
  assign par_o = (^data_i) ^ odd_i;
endmodule

// File: rtl/uart_tx_ctrl_fsm.sv
// uart_tx_ctrl_fsm: frame sequencer with one-byte hold buffer driving the TX serializer
module uart_tx_ctrl_fsm
  import uart_tx_pkg::*;
#(parameter int DATA_WIDTH = DATA_WIDTH_DEF) (
  input logic              CLK,
  input logic              RST,
  uart_tx_ctrl_fsm_if.slave bus
);
  state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] frame_q, frame_d, hold_q, hold_d, load_byte;
  logic hold_full_q, hold_full_d, par_q, par_d, par_en_q, par_en_d, par_new;
  logic xfer, in_frame, load_hold, load;
  assign xfer      = bus.Data_Valid & ~hold_full_q;
  assign in_frame  = state_q inside {START, DATA, PARITY};
  assign load_hold = (state_q == STOP) & hold_full_q;
  // a fresh byte bypasses the hold buffer whenever the frame register is free
  assign load      = load_hold | (xfer & ((state_q == IDLE) | (state_q == STOP)));
  assign load_byte = load_hold ? hold_q : bus.P_DATA;
  uart_tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .data_i(load_byte),
    .odd_i (bus.PAR_TYP),
    .par_o (par_new)
  );
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = load ? START : IDLE;
      START:   state_d = DATA;
      DATA:    state_d = !bus.ser_done ? DATA : par_en_q ? PARITY : STOP;
      PARITY:  state_d = STOP;
      STOP:    state_d = load ? START : IDLE;
      default: state_d = IDLE;
    endcase
    hold_full_d = load_hold ? 1'b0 : (xfer & in_frame) ? 1'b1 : hold_full_q;
    hold_d      = (xfer & in_frame) ? bus.P_DATA : hold_q;
    frame_d     = load ? load_byte : frame_q;
    par_d       = load ? par_new : par_q;
    par_en_d    = load ? bus.PAR_EN : par_en_q;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      par_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      par_en_q    <= par_en_d;
    end
  end
  assign bus.mux_sel    = (state_q == START)  ? MUX_START :
                          (state_q == DATA)   ? MUX_DATA  :
                          (state_q == PARITY) ? MUX_PAR   : MUX_STOP;
  assign bus.ser_en     = in_frame;
  assign bus.busy       = in_frame | (state_q == STOP);
  assign bus.data_ready = ~hold_full_q;
  assign bus.S_DATA     = frame_q;
  assign bus.par_bit    = par_q;
endmodule

// File: tb/tb_uart_tx_ctrl_fsm.sv
// tb_uart_tx_ctrl_fsm: table vectors, corner sequences and random run against a frame-position model
module tb_uart_tx_ctrl_fsm;
  import uart_tx_pkg::*;
  typedef struct {
    logic [7:0] b;
    logic       en;
    logic       typ;
    logic       exp_par;
    int         exp_len;
    logic       exp_sawpar;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_tx_ctrl_fsm_if #(.DATA_WIDTH(8)) bus ();
  uart_tx_ctrl_fsm #(.DATA_WIDTH(8)) dut (.CLK(clk), .RST(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  int dcnt;
  logic rec = 1'b0;
  logic [7:0] starts[$];
  // serializer stand-in: ser_done on the eighth data-bit cycle
  always @(posedge clk or negedge rst_n)
    if (!rst_n) dcnt <= 0;
    else dcnt <= (bus.mux_sel == MUX_DATA) ? dcnt + 1 : 0;
  assign bus.ser_done = (bus.mux_sel == MUX_DATA) && (dcnt == 7);
  always @(negedge clk) if (rec && bus.mux_sel == MUX_START) starts.push_back(bus.S_DATA);
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic drive(input logic dv, input logic [7:0] d, input logic en, input logic typ);
    bus.Data_Valid = dv;
    bus.P_DATA     = d;
    bus.PAR_EN     = en;
    bus.PAR_TYP    = typ;
  endtask
  task automatic wait_for(input logic [1:0] m, input logic b, input string n);
    int k;
    k = 0;
    while (!(bus.mux_sel == m && bus.busy == b) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(n, 32'(k < 40), 1);
  endtask
  task automatic frame(input vec_t v, output int len, output logic p, output logic [7:0] s,
                       output logic [1:0] m0, output logic sawpar, output int nd);
    @(negedge clk);
    drive(1'b1, v.b, v.en, v.typ);
    @(negedge clk);
    drive(1'b0, 8'h00, v.en, v.typ);
    m0 = bus.mux_sel;
    p = bus.par_bit;
    s = bus.S_DATA;
    len = 0;
    sawpar = 1'b0;
    nd = 0;
    while (bus.busy && len < 40) begin
      len++;
      if (bus.mux_sel == MUX_PAR) sawpar = 1'b1;
      if (bus.mux_sel == MUX_DATA) nd++;
      @(negedge clk);
    end
  endtask
  // reference model: a frame is a position counter over start, data bits, optional parity, stop
  bit m_act, m_pend, m_en, m_par;
  int m_pos, m_len;
  logic [7:0] m_byte, m_pbyte;
  task automatic m_load(input logic [7:0] b, input logic en, input logic typ);
    m_byte = b;
    m_en   = en;
    m_par  = (^b) ^ typ;
    m_len  = 10 + int'(en);
    m_pos  = 0;
    m_act  = 1'b1;
  endtask
  function automatic logic [1:0] m_mux();
    if (!m_act) return MUX_STOP;
    if (m_pos == 0) return MUX_START;
    if (m_pos <= 8) return MUX_DATA;
    if (m_pos == 9 && m_en) return MUX_PAR;
    return MUX_STOP;
  endfunction
  initial begin
    vec_t vt[5];
    vec_t v;
    int len, nd;
    logic p, sawpar, dv, en, typ, xfer;
    logic [7:0] s, d;
    logic [1:0] m0;
    vt[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11, 1'b1};
    vt[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 11, 1'b1};
    vt[2] = '{8'h01, 1'b1, 1'b0, 1'b1, 11, 1'b1};
    vt[3] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10, 1'b0};
    vt[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 10, 1'b0};
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_mux", bus.mux_sel, MUX_STOP);
    chk("rst_ser_en", bus.ser_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_par", bus.par_bit, 0);
    chk("rst_sdata", bus.S_DATA, 0);
    chk("rst_ready", bus.data_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      frame(vt[i], len, p, s, m0, sawpar, nd);
      chk($sformatf("vec%0d_start", i), m0, MUX_START);
      chk($sformatf("vec%0d_sdata", i), s, vt[i].b);
      chk($sformatf("vec%0d_par", i), p, vt[i].exp_par);
      chk($sformatf("vec%0d_len", i), len, vt[i].exp_len);
      chk($sformatf("vec%0d_sawpar", i), sawpar, vt[i].exp_sawpar);
      chk($sformatf("vec%0d_ndata", i), nd, 8);
    end
    starts.delete();
    rec = 1'b1;
    @(negedge clk);
    drive(1'b1, 8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    wait_for(MUX_DATA, 1'b1, "b2b_data");
    drive(1'b1, 8'hC3, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    chk("b2b_ready_low", bus.data_ready, 0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("b2b_ready_still_low", bus.data_ready, 0);
    wait_for(MUX_STOP, 1'b1, "b2b_stop");
    chk("b2b_stop_ready", bus.data_ready, 0);
    @(negedge clk);
    chk("b2b_restart", bus.mux_sel, MUX_START);
    chk("b2b_sdata", bus.S_DATA, 8'hC3);
    chk("b2b_ready_back", bus.data_ready, 1);
    chk("b2b_par", bus.par_bit, 0);
    wait_for(MUX_STOP, 1'b0, "b2b_idle");
    repeat (3) @(negedge clk);
    chk("b2b_nframes", starts.size(), 2);
    chk("b2b_first", starts[0], 8'h3C);
    chk("b2b_second", starts[1], 8'hC3);
    rec = 1'b0;
    @(negedge clk);
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    wait_for(MUX_DATA, 1'b1, "tog_data");
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    wait_for(MUX_PAR, 1'b1, "tog_parity");
    chk("tog_par_even", bus.par_bit, 0);
    wait_for(MUX_STOP, 1'b0, "tog_idle");
    v = '{8'hA5, 1'b1, 1'b1, 1'b1, 11, 1'b1};
    frame(v, len, p, s, m0, sawpar, nd);
    chk("tog_next_odd", p, 1);
    starts.delete();
    rec = 1'b1;
    @(negedge clk);
    drive(1'b1, 8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    wait_for(MUX_DATA, 1'b1, "rst_mid_data");
    drive(1'b1, 8'hC3, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mux", bus.mux_sel, MUX_STOP);
    chk("arst_busy", bus.busy, 0);
    chk("arst_ser_en", bus.ser_en, 0);
    chk("arst_ready", bus.data_ready, 1);
    chk("arst_sdata", bus.S_DATA, 0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{8'h5A, 1'b1, 1'b0, 1'b0, 11, 1'b1};
    frame(v, len, p, s, m0, sawpar, nd);
    chk("arst_clean_sdata", s, 8'h5A);
    chk("arst_clean_len", len, 11);
    chk("arst_clean_par", p, 0);
    repeat (3) @(negedge clk);
    chk("arst_nframes", starts.size(), 2);
    chk("arst_frame", starts[1], 8'h5A);
    rec = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_act = 1'b0; m_pend = 1'b0; m_en = 1'b0; m_par = 1'b0;
    m_pos = 0; m_len = 0; m_byte = 8'h00; m_pbyte = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      chk("rnd_mux", bus.mux_sel, m_mux());
      chk("rnd_ser_en", bus.ser_en, m_act && m_pos < m_len - 1);
      chk("rnd_busy", bus.busy, m_act);
      chk("rnd_ready", bus.data_ready, !m_pend);
      chk("rnd_sdata", bus.S_DATA, m_byte);
      chk("rnd_par", bus.par_bit, m_par);
      dv  = ($urandom_range(0, 99) < 35);
      d   = 8'($urandom);
      en  = 1'($urandom);
      typ = 1'($urandom);
      drive(dv, d, en, typ);
      @(posedge clk);
      xfer = dv && !m_pend;
      if (!m_act) begin
        if (xfer) m_load(d, en, typ);
      end else if (m_pos == m_len - 1) begin
        if (m_pend) begin
          m_pend = 1'b0;
          m_load(m_pbyte, en, typ);
        end else if (xfer) m_load(d, en, typ);
        else m_act = 1'b0;
      end else begin
        m_pos++;
        if (xfer) begin
          m_pend  = 1'b1;
          m_pbyte = d;
        end
      end
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
